// File: rtl/pad_gpio_ctrl.sv
// Per-pin GPIO pad controller: registered pad controls, input synchroniser with
// debounce filter, and sticky rise/fall edge status with a combined interrupt.
module pad_gpio_ctrl #(
  parameter int NUM_PADS    = 11,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = $clog2(DEBOUNCE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PADS-1:0] gpio_out_i,
  input  logic [NUM_PADS-1:0] gpio_dir_i,
  input  logic [NUM_PADS-1:0] gpio_pe_i,
  input  logic [NUM_PADS-1:0] gpio_ds_i,
  input  logic [NUM_PADS-1:0] irq_rise_en_i,
  input  logic [NUM_PADS-1:0] irq_fall_en_i,
  input  logic [NUM_PADS-1:0] irq_clr_i,
  output logic [NUM_PADS-1:0] gpio_in_o,
  output logic [NUM_PADS-1:0] irq_status_o,
  output logic                irq_o,
  output logic [NUM_PADS-1:0] pad_i_o,
  output logic [NUM_PADS-1:0] pad_oen_o,
  output logic [NUM_PADS-1:0] pad_ie_o,
  output logic [NUM_PADS-1:0] pad_pe_o,
  output logic [NUM_PADS-1:0] pad_ds_o,
  input  logic [NUM_PADS-1:0] pad_c_i
);

  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IN_RUN, OUT_HOLD, SETTLE} pin_state_t;

  logic [NUM_PADS-1:0] r_pad_i;
  logic [NUM_PADS-1:0] r_pad_oen;
  logic [NUM_PADS-1:0] r_pad_ie;
  logic [NUM_PADS-1:0] r_pad_pe;
  logic [NUM_PADS-1:0] r_pad_ds;

  // Pads come out of reset as plain inputs so nothing is driven before software configures them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pad_i   <= '0;
      r_pad_oen <= '1;
      r_pad_ie  <= '1;
      r_pad_pe  <= '0;
      r_pad_ds  <= '0;
    end else begin
      r_pad_i   <= gpio_out_i;
      r_pad_oen <= ~gpio_dir_i;
      r_pad_ie  <= ~gpio_dir_i;
      r_pad_pe  <= gpio_pe_i;
      r_pad_ds  <= gpio_ds_i;
    end
  end

  assign pad_i_o   = r_pad_i;
  assign pad_oen_o = r_pad_oen;
  assign pad_ie_o  = r_pad_ie;
  assign pad_pe_o  = r_pad_pe;
  assign pad_ds_o  = r_pad_ds;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pin
    pin_state_t             r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [SET_W-1:0]       r_settle;
    logic                   r_filt;
    logic                   r_status;
    logic                   w_syncOut;
    logic                   w_differ;
    logic                   w_update;
    logic                   w_set;

    assign w_syncOut = r_sync[SYNC_STAGES-1];
    assign w_differ  = (w_syncOut != r_filt);
    assign w_update  = (r_state == IN_RUN) && w_differ && (r_cnt == CNT_W'(DEBOUNCE - 1));
    assign w_set     = w_update && (w_syncOut ? irq_rise_en_i[g] : irq_fall_en_i[g]);

    // SETTLE refills the synchroniser after output mode and adopts its value without an edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state  <= IN_RUN;
        r_sync   <= '0;
        r_cnt    <= '0;
        r_settle <= '0;
        r_filt   <= 1'b0;
        r_status <= 1'b0;
      end else begin
        r_status <= w_set | (r_status & ~irq_clr_i[g]);
        case (r_state)
          IN_RUN: begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_c_i[g]};
            if (w_update) begin
              r_filt <= w_syncOut;
              r_cnt  <= '0;
            end else if (w_differ) begin
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_cnt <= '0;
            end
            if (gpio_dir_i[g]) begin
              r_state <= OUT_HOLD;
              r_cnt   <= '0;
            end
          end
          OUT_HOLD: begin
            r_cnt <= '0;
            if (!gpio_dir_i[g]) begin
              r_state  <= SETTLE;
              r_settle <= '0;
            end
          end
          SETTLE: begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_c_i[g]};
            r_cnt  <= '0;
            if (gpio_dir_i[g]) begin
              r_state <= OUT_HOLD;
            end else if (r_settle == SET_W'(SYNC_STAGES)) begin
              r_filt  <= w_syncOut;
              r_state <= IN_RUN;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          default: r_state <= IN_RUN;
        endcase
      end
    end

    assign gpio_in_o[g]    = r_filt;
    assign irq_status_o[g] = r_status;
  end

  assign irq_o = |irq_status_o;

endmodule
